// File: rtl/pc_unit_if.sv
// Request/status bundle between the fetch-stage controller and pc_unit.
// The master raises redirect/stall requests and observes the PC and RAS
// status; the slave (pc_unit) consumes the requests and reports the state.
interface pc_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              call;
    logic [ADDR_W-1:0] call_target;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output stall, branch_taken, branch_target, call, call_target, ret,
        input  pc, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, branch_target, call, call_target, ret,
        output pc, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the miniRISC fetch stage.
// Selects the next instruction address with priority ret > call > branch >
// sequential, keeps return addresses in a circular return-address stack,
// and reports sticky RAS overflow/underflow. All outputs are registered.
module pc_unit #(
    parameter int                 ADDR_W    = 32,
    parameter int                 STEP      = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'hFFFF_FFFC,
    parameter int                 RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_VAL  = ADDR_W'(STEP);

    // Architectural state
    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    // Helper signals
    logic [ADDR_W-1:0] pc_inc_s;
    logic              push_s;
    logic [PTR_W-1:0]  push_idx_s;

    // Sequential address wraps naturally at ADDR_W bits.
    assign pc_inc_s   = pc_q + STEP_VAL;
    // A push always lands one slot above the current top; when the stack
    // is full this slot holds the oldest entry, which is overwritten.
    assign push_idx_s = top_q + PTR_ONE;

    // Next-state selection: stall holds everything, otherwise ret > call > branch > sequential.
    always_comb begin
        pc_d   = pc_q;
        top_d  = top_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        push_s = 1'b0;
        if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
            // A simultaneous call is dropped entirely: no push.
            if (cnt_q != CNT_ZERO) begin
                pc_d  = ras_q[top_q];
                top_d = top_q - PTR_ONE;
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                pc_d  = pc_inc_s;
                unf_d = 1'b1;
            end
        end else if (bus.call) begin
            push_s = 1'b1;
            top_d  = push_idx_s;
            pc_d   = bus.call_target;
            if (cnt_q == CNT_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (bus.branch_taken) begin
            pc_d = bus.branch_target;
        end else begin
            pc_d = pc_inc_s;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            top_q <= '0;
            cnt_q <= CNT_ZERO;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; cleared on reset so no stale value is ever observable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push_s) begin
            ras_q[push_idx_s] <= pc_inc_s;
        end else begin
            ras_q[push_idx_s] <= ras_q[push_idx_s];
        end
    end

    assign bus.pc            = pc_q;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the miniRISC fetch stage. It supersedes the plain PC register.
- Holds the current instruction address and selects the next one from sequential increment, branch/jump redirect, call or return.
- Return addresses come from an internal circular return-address stack (RAS).
- Adds a stall hold, a configurable reset address and RAS overflow/underflow status flags.

Parameters:
- ADDR_W, 32: PC and target width in bits.
- STEP, 4: sequential increment in bytes.
- RESET_PC, 32'hFFFF_FFFC: PC value held in reset. The first unstalled cycle then yields 0.
- RAS_DEPTH, 4: RAS entries. Must be a power of two, ≥2.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset. 0 = reset asserted.
- stall, input, 1: hold PC and RAS this cycle.
- branch_taken, input, 1: redirect to branch_target.
- branch_target, input, ADDR_W: branch/jump destination.
- call, input, 1: push return address, redirect to call_target.
- call_target, input, ADDR_W: call destination.
- ret, input, 1: pop RAS, redirect to popped address.
- pc, output, ADDR_W: registered current instruction address.
- ras_count, output, clog2(RAS_DEPTH)+1: valid RAS entries, range 0..RAS_DEPTH.
- ras_overflow, output, 1: sticky; a push occurred while full.
- ras_underflow, output, 1: sticky; a pop occurred while empty.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately without a clock edge):
  - pc = RESET_PC; ras_count = 0; ras_overflow = 0; ras_underflow = 0.
  - RAS write pointer = 0. RAS entry contents are don't-care.
  - Reset asserted mid-call or mid-ret discards the operation.
- Release: outputs update only on rising clk edges after rst returns to 1.
- Per edge, with rst=1:
  - stall=1: pc, RAS pointer, ras_count and the flags all hold. branch_taken, call and ret are ignored, not queued; the upstream stage must hold them until stall drops.
  - stall=0: next PC is chosen by fixed priority ret > call > branch_taken > sequential.
    - ret with ras_count>0: pc <= RAS[top]; top pointer decrements (mod RAS_DEPTH); ras_count -= 1.
    - ret with ras_count=0: pc <= pc+STEP; ras_underflow <= 1; pointer and ras_count unchanged.
    - call with ras_count<RAS_DEPTH: RAS[top+1] <= pc+STEP; pointer increments; ras_count += 1; pc <= call_target.
    - call with ras_count=RAS_DEPTH: the push overwrites the oldest entry (circular); pointer increments; ras_count stays RAS_DEPTH; ras_overflow <= 1; pc <= call_target.
    - branch_taken: pc <= branch_target.
    - Otherwise: pc <= pc+STEP.
- Simultaneous ret and call in one cycle: only ret acts. The call is dropped, with no push.
- Arithmetic: pc+STEP is truncated to ADDR_W, so it wraps modulo 2^ADDR_W. For example, 32'hFFFF_FFFC+4 = 0.
- Target alignment is not checked; targets are taken verbatim.
- Latency: a redirect requested in cycle N is visible on pc after edge N. pc is purely registered, with no combinational input-to-output path.
- Sticky flags clear only on reset.

Test Plan:
- Reset and run: rst=0, then release, no requests, 3 edges → pc sequence FFFF_FFFC, 0, 4, 8. Async check: assert rst between edges → pc = FFFF_FFFC immediately, flags 0, ras_count 0.
- Stall with redirect: at pc=8, stall=1 with branch_taken=1 and branch_target=0x100 for 2 edges → pc stays 8. Then stall=0 with branch held → pc=0x100 after 1 edge.
- Call/return nesting: at pc=0x10, call to 0x200; at 0x200, call to 0x300; then ret, ret.
  - pc sequence: 0x200, 0x300, 0x204, 0x14.
  - ras_count sequence: 1, 2, 1, 0.
  - ras_underflow stays 0.
- Overflow (RAS_DEPTH=4): 5 consecutive calls from pc=0, 0x40, 0x80, 0xC0, 0x100 → ras_count=4, ras_overflow=1. Then 4 rets → return to 0x104, 0xC4, 0x84, 0x44; the oldest return address (4) was lost.
- Underflow and priority:
  - ret with ras_count=0 at pc=0x20 → pc=0x24, ras_underflow=1.
  - ret+call+branch together with one entry holding 0x58 → pc=0x58, no push, ras_count=0.
  - call+branch together → call wins, pc=call_target.
- Wrap: force pc to FFFF_FFF8 via branch, then 2 sequential edges → FFFF_FFFC, 0.
